// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch stage:
// fetch FSM state type, base opcodes and the canonical NOP encoding.
package riscv_pkg;

  // Fetch controller states
  typedef enum logic [2:0] {
    IFS_IDLE = 3'd0,
    IFS_REQ  = 3'd1,
    IFS_WAIT = 3'd2,
    IFS_HOLD = 3'd3,
    IFS_DROP = 3'd4
  } ifetch_state_t;

  // OP-IMM major opcode (ADDI and friends)
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEFAULT = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

endpackage : riscv_pkg

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one memory read per instruction, holds the
// returned word for the decoder and counts instructions the decoder accepts.
// Optional build macro IFETCH_MISALIGN_CHECK_EN: a misaligned PC skips the
// memory access and presents NOP_INSTR with instr_fault set instead.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int          ADDR_SIZE = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] pc,
  output logic                 pc_enable,
  input  logic                 flush,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [ADDR_SIZE-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [ADDR_SIZE-1:0] instr_pc,
  output logic                 instr_fault,
  output logic [31:0]          fetch_count
);

  ifetch_state_t        state_q, state_d;
  logic [31:0]          instr_q, instr_d;
  logic [ADDR_SIZE-1:0] instr_pc_q, instr_pc_d;
  logic                 instr_fault_q, instr_fault_d;
  logic [31:0]          fetch_count_q, fetch_count_d;

  logic misaligned;
  logic req_accept;   // memory takes the request this cycle
  logic fault_take;   // misaligned PC replaced by a NOP this cycle
  logic rsp_take;     // response captured into the holding register
  logic dec_accept;   // decoder takes the held instruction

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign req_accept = (state_q == IFS_REQ)  && !flush && !misaligned && imem_req_ready;
  assign fault_take = (state_q == IFS_REQ)  && !flush && misaligned;
  assign rsp_take   = (state_q == IFS_WAIT) && !flush && imem_rsp_valid;
  assign dec_accept = (state_q == IFS_HOLD) && !flush && instr_ready;

  // Next-state logic: a flush always redirects back to REQ, except while a
  // response is still owed, where DROP swallows it first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IFS_IDLE: state_d = IFS_REQ;
      IFS_REQ: begin
        if (fault_take)      state_d = IFS_HOLD;
        else if (req_accept) state_d = IFS_WAIT;
      end
      IFS_WAIT: begin
        if (imem_rsp_valid)  state_d = flush ? IFS_REQ : IFS_HOLD;
        else if (flush)      state_d = IFS_DROP;
      end
      IFS_HOLD: begin
        if (flush || instr_ready) state_d = IFS_REQ;
      end
      IFS_DROP: begin
        if (imem_rsp_valid)  state_d = IFS_REQ;
      end
      default: state_d = IFS_IDLE;
    endcase
  end

  // Holding register and counter updates
  always_comb begin
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_fault_d = instr_fault_q;
    fetch_count_d = fetch_count_q;
    if (req_accept || fault_take) instr_pc_d = pc;
    if (fault_take) begin
      instr_d       = NOP_INSTR;
      instr_fault_d = 1'b1;
    end else if (rsp_take) begin
      instr_d       = imem_rsp_data;
      instr_fault_d = 1'b0;
    end
    if (dec_accept) fetch_count_d = fetch_count_q + 32'd1;
  end

  // Moore/Mealy outputs of the fetch FSM
  always_comb begin
    imem_req_valid = (state_q == IFS_REQ) && !flush && !misaligned;
    imem_req_addr  = (state_q == IFS_REQ) ? pc : '0;
    instr_valid    = (state_q == IFS_HOLD);
    pc_enable      = dec_accept;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all registers here are plain flops (no storage arrays), so every one is reset.
    if (!rst_n) begin
      state_q       <= IFS_IDLE;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_fault_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample together.
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_fault_q <= instr_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_fault = instr_fault_q;
  assign fetch_count = fetch_count_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. The reference model is transaction
// level: each fetch expects the data returned for the address it requested,
// and the expected count is the number of decoder acceptances so far.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_enable;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic [31:0] fetch_count;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model_count;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_enable      (pc_enable),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_fault    (instr_fault),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  // advance to 2 time units after the next rising edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_pc();
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  // One complete fetch from REQ back to REQ with configurable stalls.
  task automatic do_fetch(input logic [31:0] p, input logic [31:0] d,
                          input int rd, input int sd, input int ad, input bit preset);
    pc = p; flush = 0; imem_req_ready = 0; imem_rsp_valid = 0; instr_ready = 0;
    for (int i = 0; i < rd; i++) begin
      #1;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== p || pc_enable !== 1'b0) begin
        n_fail++; $display("FAIL req_stall: valid=%b addr=%h pc_en=%b want 1 %h 0", imem_req_valid, imem_req_addr, pc_enable, p);
      end
      n_cmp++;
      step();
    end
    imem_req_ready = 1; #1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== p) begin
      n_fail++; $display("FAIL req_issue: valid=%b addr=%h want 1 %h", imem_req_valid, imem_req_addr, p);
    end
    n_cmp++;
    step(); imem_req_ready = 0;
    for (int i = 0; i < sd; i++) begin
      #1;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL wait: instr_valid=%b req_valid=%b want 0 0", instr_valid, imem_req_valid);
      end
      n_cmp++;
      step();
    end
    imem_rsp_valid = 1; imem_rsp_data = d; #1;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL rsp_cycle: instr_valid=%b want 0", instr_valid);
    end
    n_cmp++;
    step(); imem_rsp_valid = 0; imem_rsp_data = $urandom;
    for (int i = 0; i < ad; i++) begin
      imem_rsp_valid = 1'($urandom_range(0, 1));  // stray responses in HOLD are ignored
      #1;
      if (instr_valid !== 1'b1 || instr !== d || instr_pc !== p || instr_fault !== 1'b0 || pc_enable !== 1'b0) begin
        n_fail++; $display("FAIL hold: v=%b instr=%h pc=%h fault=%b pc_en=%b want 1 %h %h 0 0", instr_valid, instr, instr_pc, instr_fault, pc_enable, d, p);
      end
      n_cmp++;
      step(); imem_rsp_valid = 0;
    end
    if (preset) begin
      force dut.fetch_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_count_q;
      model_count = 32'hFFFF_FFFF;
    end
    instr_ready = 1; #1;
    if (pc_enable !== 1'b1 || instr_valid !== 1'b1 || instr !== d || instr_pc !== p) begin
      n_fail++; $display("FAIL accept: pc_en=%b v=%b instr=%h pc=%h want 1 1 %h %h", pc_enable, instr_valid, instr, instr_pc, d, p);
    end
    n_cmp++;
    step(); instr_ready = 0;
    model_count = model_count + 32'd1;
    #1;
    if (fetch_count !== model_count || instr_valid !== 1'b0 || pc_enable !== 1'b0 || imem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL after_accept: count=%h v=%b pc_en=%b req=%b want %h 0 0 1", fetch_count, instr_valid, pc_enable, imem_req_valid, model_count);
    end
    n_cmp++;
  endtask

  // Drive REQ -> WAIT -> HOLD with no stalls, no checks.
  task automatic to_hold(input logic [31:0] p, input logic [31:0] d);
    pc = p; imem_req_ready = 1; step(); imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = d; step(); imem_rsp_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; pc = 32'h4; flush = 0; imem_req_ready = 0; imem_rsp_valid = 0;
    imem_rsp_data = 0; instr_ready = 0; model_count = 0;
    step(); step(); #1;
    if (imem_req_valid !== 0 || instr_valid !== 0 || pc_enable !== 0 || instr !== 0 ||
        instr_pc !== 0 || instr_fault !== 0 || fetch_count !== 0) begin
      n_fail++; $display("FAIL reset_state: req=%b v=%b pc_en=%b instr=%h ipc=%h fault=%b count=%h want all 0",
                         imem_req_valid, instr_valid, pc_enable, instr, instr_pc, instr_fault, fetch_count);
    end
    n_cmp++;
    rst_n = 1; step(); #1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
      n_fail++; $display("FAIL reset_release: req=%b addr=%h want 1 00000004", imem_req_valid, imem_req_addr);
    end
    n_cmp++;
  endtask

  task automatic test_basic();
    do_fetch(32'h4, 32'h0050_0093, 0, 0, 0, 0);
  endtask

  task automatic test_req_stall();
    do_fetch(rand_pc(), $urandom, 5, 1, 2, 0);
  endtask

  task automatic test_flush_req();
    pc = rand_pc(); flush = 1; imem_req_ready = 1; #1;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_req: req_valid=%b want 0", imem_req_valid);
    end
    n_cmp++;
    step(); flush = 0; imem_req_ready = 0; #1;
    if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_req_stay: req=%b v=%b want 1 0", imem_req_valid, instr_valid);
    end
    n_cmp++;
    do_fetch(rand_pc(), $urandom, 0, 0, 1, 0);
  endtask

  task automatic test_flush_wait();
    logic [31:0] p2;
    pc = rand_pc(); imem_req_ready = 1; step(); imem_req_ready = 0;
    flush = 1; step(); flush = 0; #1;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_enter: req=%b v=%b want 0 0", imem_req_valid, instr_valid);
    end
    n_cmp++;
    flush = 1; step(); flush = 0; #1;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_reflush: req=%b v=%b want 0 0", imem_req_valid, instr_valid);
    end
    n_cmp++;
    step();
    imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; step(); imem_rsp_valid = 0;
    p2 = rand_pc(); pc = p2; #1;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== p2 || instr === 32'hDEAD_BEEF || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL drop_exit: req=%b addr=%h instr=%h v=%b want 1 %h !deadbeef 0", imem_req_valid, imem_req_addr, instr, instr_valid, p2);
    end
    n_cmp++;
    do_fetch(p2, $urandom, 0, 2, 0, 0);
  endtask

  task automatic test_flush_wait_rsp();
    pc = rand_pc(); imem_req_ready = 1; step(); imem_req_ready = 0;
    flush = 1; imem_rsp_valid = 1; imem_rsp_data = 32'hCAFE_F00D; step();
    flush = 0; imem_rsp_valid = 0; #1;
    if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0 || instr === 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL flush_wait_rsp: req=%b v=%b instr=%h want 1 0 !cafef00d", imem_req_valid, instr_valid, instr);
    end
    n_cmp++;
    do_fetch(rand_pc(), $urandom, 1, 0, 0, 0);
  endtask

  task automatic test_flush_hold();
    to_hold(rand_pc(), $urandom);
    instr_ready = 1; flush = 1; #1;
    if (pc_enable !== 1'b0 || instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL flush_hold: pc_en=%b v=%b want 0 1", pc_enable, instr_valid);
    end
    n_cmp++;
    step(); instr_ready = 0; flush = 0; #1;
    if (fetch_count !== model_count || imem_req_valid !== 1'b1 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_hold_after: count=%h req=%b v=%b want %h 1 0", fetch_count, imem_req_valid, instr_valid, model_count);
    end
    n_cmp++;
  endtask

  task automatic test_misalign();
    pc = 32'h6; imem_req_ready = 1; #1;
`ifdef IFETCH_MISALIGN_CHECK_EN
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL misalign_req: req=%b want 0", imem_req_valid);
    end
    n_cmp++;
    step(); imem_req_ready = 0; pc = 32'h8; #1;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_0013 || instr_pc !== 32'h6 || instr_fault !== 1'b1) begin
      n_fail++; $display("FAIL misalign_hold: v=%b instr=%h pc=%h fault=%b want 1 00000013 00000006 1", instr_valid, instr, instr_pc, instr_fault);
    end
    n_cmp++;
    instr_ready = 1; step(); instr_ready = 0; model_count = model_count + 32'd1; #1;
    if (fetch_count !== model_count) begin
      n_fail++; $display("FAIL misalign_count: count=%h want %h", fetch_count, model_count);
    end
    n_cmp++;
`else
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h6 || instr_fault !== 1'b0) begin
      n_fail++; $display("FAIL misalign_off: req=%b addr=%h fault=%b want 1 00000006 0", imem_req_valid, imem_req_addr, instr_fault);
    end
    n_cmp++;
    imem_req_ready = 0;
    do_fetch(32'h6, $urandom, 0, 0, 0, 0);
`endif
    do_fetch(rand_pc(), $urandom, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    pc = rand_pc(); imem_req_ready = 1; step(); imem_req_ready = 0;
    #1; rst_n = 0; #1;
    if (imem_req_valid !== 0 || instr_valid !== 0 || pc_enable !== 0 || instr !== 0 ||
        instr_pc !== 0 || instr_fault !== 0 || fetch_count !== 0) begin
      n_fail++; $display("FAIL reset_mid: req=%b v=%b pc_en=%b instr=%h ipc=%h fault=%b count=%h want all 0",
                         imem_req_valid, instr_valid, pc_enable, instr, instr_pc, instr_fault, fetch_count);
    end
    n_cmp++;
    model_count = 0;
    step(); imem_rsp_valid = 1; imem_rsp_data = 32'hBAAD_F00D;
    step(); rst_n = 1;
    step(); #1;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || instr !== 32'h0) begin
      n_fail++; $display("FAIL late_rsp: v=%b req=%b instr=%h want 0 1 00000000", instr_valid, imem_req_valid, instr);
    end
    n_cmp++;
    step(); imem_rsp_valid = 0; #1;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL late_rsp2: v=%b req=%b want 0 1", instr_valid, imem_req_valid);
    end
    n_cmp++;
    do_fetch(rand_pc(), $urandom, 0, 0, 1, 1);   // preset count to all-ones, expect wrap to 0
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_fetch(rand_pc(), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_flush_req();
    test_flush_wait();
    test_flush_wait_rsp();
    test_flush_hold();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_SIZE, default 32: width of PC and memory address.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction word substituted on fault.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pc  input  ADDR_SIZE  current PC from program counter.
REQ-006 pc_enable  output  1  one-cycle pulse; advances the program counter.
REQ-007 flush  input  1  redirect; discard any fetched or in-flight instruction.
REQ-008 imem_req_valid / imem_req_ready  output / input  1 each  fetch request handshake.
REQ-009 imem_req_addr  output  ADDR_SIZE  fetch address.
REQ-010 imem_rsp_valid / imem_rsp_data  input  1 / 32  read response; no backpressure.
REQ-011 instr_valid / instr_ready  output / input  1 each  decoder handshake.
REQ-012 instr / instr_pc  output  32 / ADDR_SIZE  held instruction and its address.
REQ-013 instr_fault  output  1  held instruction replaced due to misaligned PC.
REQ-014 fetch_count  output  32  count of instructions accepted by the decoder.

Function
REQ-015 FSM states: IDLE, REQ, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-016 IDLE -> REQ unconditionally on the first clock after reset release.
REQ-017 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready capture pc into instr_pc and go to WAIT.
REQ-018 WAIT: on imem_rsp_valid register imem_rsp_data into instr and go to HOLD; instr_valid rises the cycle after imem_rsp_valid.
REQ-019 HOLD: instr_valid=1, instr/instr_pc stable; on instr_valid&&instr_ready pulse pc_enable that cycle, increment fetch_count (wraps 2^32-1 -> 0), go to REQ.
REQ-020 Minimum loop: req accept cycle N, rsp N+1, instr_valid N+2, accept N+2, next request N+3.
REQ-021 flush in REQ: stay in REQ, no request accepted that cycle; flush in WAIT without imem_rsp_valid: go to DROP.
REQ-022 flush in WAIT with imem_rsp_valid same cycle: discard the response, go to REQ.
REQ-023 DROP: imem_req_valid=0; discard next imem_rsp_valid, then go to REQ; a further flush in DROP is ignored.
REQ-024 flush in HOLD: go to REQ, no pc_enable, fetch_count unchanged, even if instr_ready=1 same cycle (flush wins).
REQ-025 instr_valid=0 and pc_enable=0 in every state other than HOLD.
REQ-026 imem_rsp_valid outside WAIT/DROP is ignored.

Reset
REQ-027 While rst_n=0: state=IDLE; instr=0; instr_pc=0; instr_fault=0; fetch_count=0; imem_req_valid=0; instr_valid=0; pc_enable=0.
REQ-028 Reset assertion mid-transaction aborts immediately; a response arriving after release is ignored (state IDLE/REQ).

Configuration
REQ-029 Macro IFETCH_MISALIGN_CHECK_EN compiles in PC alignment checking.
REQ-030 Defined: in REQ with pc[1:0]!=0, no memory request; next cycle HOLD with instr=NOP_INSTR, instr_pc=pc, instr_fault=1.
REQ-031 Undefined: pc[1:0] ignored, address issued unchanged, instr_fault tied 0.

Structure
REQ-032 Shared package riscv_pkg holds ifetch_state_t enum, NOP_INSTR default value, opcode constants.
REQ-033 No sub-module; FSM, holding register and counter in one module.

Verification
REQ-034 pc=0x4, ready=1, rsp 1 cycle later 0x00500093 -> instr_valid with instr=0x00500093, instr_pc=0x4; accept -> one pc_enable pulse, fetch_count=1.
REQ-035 imem_req_ready low 5 cycles -> imem_req_valid held, addr stable, no pc_enable.
REQ-036 flush in WAIT, rsp 3 cycles later 0xDEADBEEF -> response dropped, new request for current pc, instr never 0xDEADBEEF.
REQ-037 HOLD with instr_ready=1 and flush=1 same cycle -> no pc_enable, fetch_count unchanged, new request next cycle.
REQ-038 Macro defined, pc=0x6 -> no imem_req_valid, instr=0x00000013, instr_fault=1; undefined -> imem_req_addr=0x6.
REQ-039 rst_n low mid-WAIT -> all outputs zero immediately; late rsp ignored; fetch_count preset 0xFFFFFFFF wraps to 0 on accept.
